jedro_1_dmem_responder: RTL

JEDRO_1_DMEM_RESPONDER -- requirements
Module: jedro_1_dmem_responder

---
 rtl/jedro_1_dmem_responder.sv | 115 +++++++++++
 1 files changed

// File: rtl/jedro_1_dmem_responder.sv
// Single-port data memory slave with fixed request-to-response latency and byte-enabled writes.
// Define JEDRO_1_DMEM_MISALIGN_ERR_EN to flag (and suppress) accesses with addr[1:0] != 0.
module jedro_1_dmem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [3:0]            be_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  we_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            be_q;
    logic                  err_q;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic                  misalign;
    logic                  resp_we;
    logic                  resp_err;
    logic [IDX_W-1:0]      resp_idx;
    logic [DATA_WIDTH-1:0] resp_data;

`ifdef JEDRO_1_DMEM_MISALIGN_ERR_EN
    assign misalign = |addr_i[1:0];
`else
    assign misalign = 1'b0;
`endif

    assign gnt_o = (state == IDLE);

    // With LATENCY == 1 the response is formed straight from the request fields.
    assign resp_we   = (state == IDLE) ? we_i : we_q;
    assign resp_err  = (state == IDLE) ? misalign : err_q;
    assign resp_idx  = (state == IDLE) ? addr_i[IDX_W+1:2] : idx_q;
    assign resp_data = (!resp_we && !resp_err) ? mem[resp_idx] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            be_q     <= 4'd0;
            err_q    <= 1'b0;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        idx_q   <= addr_i[IDX_W+1:2];
                        wdata_q <= wdata_i;
                        be_q    <= be_i;
                        err_q   <= misalign;
                        if (LATENCY == 1) begin
                            state    <= RESP;
                            rvalid_o <= 1'b1;
                            rdata_o  <= resp_data;
                            err_o    <= resp_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state    <= RESP;
                        rvalid_o <= 1'b1;
                        rdata_o  <= resp_data;
                        err_o    <= resp_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Commit on the edge that ends RESP; an async reset in RESP leaves state != RESP here.
    always_ff @(posedge clk_i) begin
        if (state == RESP && we_q && !err_q) begin
            for (int k = 0; k < 4; k++) begin
                if (be_q[k]) mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
            end
        end
    end
endmodule
